// File: rtl/pc_fetch_ctrl_pkg.sv
// Shared constants and state encoding for the fetch PC controller.
package pc_fetch_ctrl_pkg;

   localparam logic [31:0] PC_RESET   = 32'h0000_3000;
   localparam logic [31:0] EXC_VECTOR = 32'h0000_4180;
   localparam logic [31:0] TEXT_LO    = 32'h0000_3000;
   localparam logic [31:0] TEXT_HI    = 32'h0000_6FFC;
   localparam logic [4:0]  EXC_ADEL   = 5'd4;

   typedef enum logic {
      RUN  = 1'b0,
      PEND = 1'b1
   } fetch_state_e;

endpackage

// File: rtl/pc_fetch_ctrl_next_sel.sv
// Combinational priority select of next PC, state and latched branch target.
module pc_next_sel
   import pc_fetch_ctrl_pkg::*;
(
   input  fetch_state_e state_i,
   input  logic [31:0]  pc_i,
   input  logic [31:0]  tgt_i,
   input  logic         advance_i,
   input  logic         exc_req_i,
   input  logic         eret_req_i,
   input  logic [31:0]  epc_i,
   input  logic         br_req_i,
   input  logic [31:0]  br_target_i,
   output logic [31:0]  pc_o,
   output fetch_state_e state_o,
   output logic [31:0]  tgt_o,
   output logic         redirect_o
);

   always_comb begin
      pc_o       = pc_i;
      state_o    = state_i;
      tgt_o      = tgt_i;
      redirect_o = 1'b0;
      if (exc_req_i) begin
         pc_o       = EXC_VECTOR;
         state_o    = RUN;
         tgt_o      = '0;
         redirect_o = 1'b1;
      end else if (eret_req_i) begin
         pc_o       = epc_i;
         state_o    = RUN;
         tgt_o      = '0;
         redirect_o = 1'b1;
      end else if (br_req_i) begin
         if (advance_i) begin
            pc_o       = br_target_i;
            state_o    = RUN;
            redirect_o = 1'b1;
         end else begin
            // F is held: park the target until the fetch can move
            tgt_o   = br_target_i;
            state_o = PEND;
         end
      end else if (advance_i) begin
         if (state_i == PEND) begin
            pc_o       = tgt_i;
            state_o    = RUN;
            redirect_o = 1'b1;
         end else begin
            pc_o = pc_i + 32'd4;
         end
      end
   end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// Fetch PC register and branch-pending state machine.
// Optional PC_ALIGN_CHECK_EN enables the fetch address error flag.
module pc_fetch_ctrl
   import pc_fetch_ctrl_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        stall_i,
   input  logic        im_ready_i,
   input  logic        exc_req_i,
   input  logic        eret_req_i,
   input  logic [31:0] epc_i,
   input  logic        br_req_i,
   input  logic [31:0] br_target_i,
   output logic [31:0] pc_o,
   output logic        pend_o,
   output logic        redirect_o,
   output logic        adel_o,
   output logic [4:0]  exccode_o
);

   fetch_state_e state_q, state_d;
   logic [31:0]  pc_q, pc_d;
   logic [31:0]  tgt_q, tgt_d;
   logic         redirect_q, redirect_d;
   logic         advance;

   assign advance = !stall_i && im_ready_i;

   pc_next_sel u_next_sel (
      .state_i     (state_q),
      .pc_i        (pc_q),
      .tgt_i       (tgt_q),
      .advance_i   (advance),
      .exc_req_i   (exc_req_i),
      .eret_req_i  (eret_req_i),
      .epc_i       (epc_i),
      .br_req_i    (br_req_i),
      .br_target_i (br_target_i),
      .pc_o        (pc_d),
      .state_o     (state_d),
      .tgt_o       (tgt_d),
      .redirect_o  (redirect_d)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         pc_q       <= PC_RESET;
         state_q    <= RUN;
         tgt_q      <= '0;
         redirect_q <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         state_q    <= state_d;
         tgt_q      <= tgt_d;
         redirect_q <= redirect_d;
      end
   end

   assign pc_o       = pc_q;
   assign pend_o     = (state_q == PEND);
   assign redirect_o = redirect_q;

`ifdef PC_ALIGN_CHECK_EN
   // Flag only; the exception itself comes back in through exc_req_i
   assign adel_o    = (pc_q[1:0] != 2'b00) || (pc_q < TEXT_LO) || (pc_q > TEXT_HI);
   assign exccode_o = adel_o ? EXC_ADEL : 5'd0;
`else
   assign adel_o    = 1'b0;
   assign exccode_o = 5'd0;
`endif

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed self-checking bench for pc_fetch_ctrl.
module tb_pc_fetch_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic        stall_i, im_ready_i, exc_req_i, eret_req_i, br_req_i;
   logic [31:0] epc_i, br_target_i;
   logic [31:0] pc_o;
   logic        pend_o, redirect_o, adel_o;
   logic [4:0]  exccode_o;

   int n_cmp = 0;
   int n_err = 0;

   pc_fetch_ctrl dut (
      .clk         (clk),
      .reset       (reset),
      .stall_i     (stall_i),
      .im_ready_i  (im_ready_i),
      .exc_req_i   (exc_req_i),
      .eret_req_i  (eret_req_i),
      .epc_i       (epc_i),
      .br_req_i    (br_req_i),
      .br_target_i (br_target_i),
      .pc_o        (pc_o),
      .pend_o      (pend_o),
      .redirect_o  (redirect_o),
      .adel_o      (adel_o),
      .exccode_o   (exccode_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   // Drive one cycle of inputs, clock it, then sample 1ns after the edge.
   task automatic cyc(input logic rst, input logic stall, input logic rdy,
                      input logic exc, input logic eret, input logic [31:0] epc,
                      input logic br, input logic [31:0] bt);
      reset = rst; stall_i = stall; im_ready_i = rdy;
      exc_req_i = exc; eret_req_i = eret; epc_i = epc;
      br_req_i = br; br_target_i = bt;
      @(posedge clk);
      #1;
   endtask

   task automatic adv();
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
   endtask

   task automatic chk_state(input string tag, input logic [31:0] pc, input logic pend,
                            input logic redir);
      chk({tag, ".pc"}, pc_o, pc);
      chk({tag, ".pend"}, {31'b0, pend_o}, {31'b0, pend});
      chk({tag, ".redir"}, {31'b0, redirect_o}, {31'b0, redir});
   endtask

   // Hand-written address-error expectations; adel_exp is the value with the check enabled.
   task automatic chk_adel(input string tag, input logic adel_exp);
`ifdef PC_ALIGN_CHECK_EN
      chk({tag, ".adel"}, {31'b0, adel_o}, {31'b0, adel_exp});
      chk({tag, ".code"}, {27'b0, exccode_o}, adel_exp ? 32'd4 : 32'd0);
`else
      chk({tag, ".adel"}, {31'b0, adel_o}, 32'd0);
      chk({tag, ".code"}, {27'b0, exccode_o}, 32'd0);
`endif
   endtask

   initial begin
      // Reset with a competing exception request: reset wins
      cyc(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      cyc(1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_state("reset", 32'h3000, 1'b0, 1'b0);
      chk_adel("reset", 1'b0);

      adv(); chk_state("seq1", 32'h3004, 1'b0, 1'b0);
      adv(); chk_state("seq2", 32'h3008, 1'b0, 1'b0);
      adv(); chk_state("seq3", 32'h300C, 1'b0, 1'b0);
      adv(); chk_state("seq4", 32'h3010, 1'b0, 1'b0);

      // Branch while stalled: two pending cycles, then release
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3400);
      chk_state("pend1", 32'h3010, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_state("pend2", 32'h3010, 1'b1, 1'b0);
      adv(); chk_state("pend_rel", 32'h3400, 1'b0, 1'b1);
      adv(); chk_state("pend_after", 32'h3404, 1'b0, 1'b0);

      // Exception while pending discards the target
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3400);
      chk_state("pend_b", 32'h3404, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_state("exc_in_pend", 32'h4180, 1'b0, 1'b1);
      adv(); chk_state("exc_after", 32'h4184, 1'b0, 1'b0);

      // Simultaneous requests: exception first, then eret
      cyc(1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 32'h3020, 1'b1, 32'h3500);
      chk_state("prio_exc", 32'h4180, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h3020, 1'b0, 32'h0);
      chk_state("eret", 32'h3020, 1'b0, 1'b1);

      // A later branch in PEND overwrites the latched target
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3500);
      chk_state("ovw1", 32'h3020, 1'b1, 1'b0);
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3600);
      chk_state("ovw2", 32'h3020, 1'b1, 1'b0);
      adv(); chk_state("ovw_rel", 32'h3600, 1'b0, 1'b1);

      // Hold with im_ready low and no request
      cyc(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_state("hold", 32'h3600, 1'b0, 1'b0);

      // Branch with advance: immediate load
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3100);
      chk_state("br_adv", 32'h3100, 1'b0, 1'b1);

      // Wrap at top of address space
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'h0);
      chk_state("wrap_pre", 32'hFFFF_FFFC, 1'b0, 1'b1);
      chk_adel("wrap_pre", 1'b1);
      adv(); chk_state("wrap", 32'h0000_0000, 1'b0, 1'b0);
      chk_adel("wrap", 1'b1);

      // Misaligned and text-range boundaries
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h3002, 1'b0, 32'h0);
      chk_state("mis", 32'h3002, 1'b0, 1'b1);
      chk_adel("mis", 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h6FFC, 1'b0, 32'h0);
      chk_state("hi_edge", 32'h6FFC, 1'b0, 1'b1);
      chk_adel("hi_edge", 1'b0);
      adv(); chk_state("hi_out", 32'h7000, 1'b0, 1'b0);
      chk_adel("hi_out", 1'b1);
      cyc(1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 32'h2FFC, 1'b0, 32'h0);
      chk_adel("lo_out", 1'b1);

      // Reset mid-PEND drops the latched target
      cyc(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b1, 32'h3800);
      chk_state("rst_pend", 32'h2FFC, 1'b1, 1'b0);
      cyc(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 32'h0, 1'b0, 32'h0);
      chk_state("rst_mid", 32'h3000, 1'b0, 1'b0);
      adv(); chk_state("rst_after", 32'h3004, 1'b0, 1'b0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pc_fetch_ctrl.md
PC_FETCH_CTRL -- requirements
Module: pc_fetch_ctrl

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  synchronous, active-high; sampled only on rising edge of clk.
REQ-003 SHALL have port: stall_i  input  1  hazard-unit stall; F stage must hold.
REQ-004 SHALL have port: im_ready_i  input  1  instruction memory accepted current pc_o.
REQ-005 SHALL have port: exc_req_i  input  1  exception/interrupt redirect request.
REQ-006 SHALL have port: eret_req_i  input  1  eret redirect request.
REQ-007 SHALL have port: epc_i  input  32  eret target.
REQ-008 SHALL have port: br_req_i  input  1  taken branch/jump resolved in D.
REQ-009 SHALL have port: br_target_i  input  32  branch/jump target.
REQ-010 SHALL have port: pc_o  output  32  current fetch PC.
REQ-011 SHALL have port: pend_o  output  1  branch target held pending.
REQ-012 SHALL have port: redirect_o  output  1  one-cycle pulse: pc_o just loaded from a non-sequential source.
REQ-013 SHALL have port: adel_o  output  1  fetch address error.
REQ-014 SHALL have port: exccode_o  output  5  exception code for adel_o.

Function
REQ-015 SHALL define advance = !stall_i && im_ready_i.
REQ-016 SHALL implement states RUN and PEND; pend_o = (state==PEND).
REQ-017 SHALL apply this per-cycle priority: exc_req_i > eret_req_i > br_req_i > pending target > sequential.
REQ-018 exc_req_i SHALL load pc 0x0000_4180, clear pending, go RUN, regardless of advance.
REQ-019 eret_req_i without exc_req_i SHALL load epc_i, clear pending, go RUN, regardless of advance.
REQ-020 br_req_i with advance SHALL load br_target_i and go RUN; the delay slot is the PC held when the request arrives.
REQ-021 br_req_i without advance SHALL latch br_target_i, go PEND, and hold pc; a later br_req_i in PEND SHALL overwrite the latched target.
REQ-022 In PEND with advance and no request, SHALL load the latched target and go RUN.
REQ-023 With no request and advance in RUN, SHALL load pc+4, modulo 2^32; 0xFFFF_FFFC wraps to 0x0000_0000.
REQ-024 With no request and no advance, SHALL hold pc and state.
REQ-025 redirect_o SHALL be 1 in the cycle after any load per REQ-018..020 or REQ-022, else 0.
REQ-026 Redirect latency SHALL be one cycle: request at edge N gives the new pc_o after edge N.

Reset
REQ-027 reset SHALL take priority over all inputs: pc_o=0x0000_3000, state RUN, pend_o=0, redirect_o=0, latched target=0.
REQ-028 reset asserted mid-PEND SHALL discard the latched target.

Configuration
REQ-029 With PC_ALIGN_CHECK_EN defined, adel_o SHALL be 1 when pc_o[1:0]!=0 or pc_o lies outside 0x0000_3000..0x0000_6FFC, with exccode_o=5'd4; the controller SHALL still only redirect on exc_req_i.
REQ-030 Without PC_ALIGN_CHECK_EN, adel_o SHALL be tied 0 and exccode_o tied 5'd0.

Structure
REQ-031 SHALL take PC_RESET (0x3000), EXC_VECTOR (0x4180), text-range bounds, EXC_ADEL (4) and state encodings from the shared constant header/package.
REQ-032 SHALL place the combinational priority next-PC select in one sub-module, pc_next_sel; state and registers stay in pc_fetch_ctrl.

Verification
REQ-033 reset then 3 cycles of advance -> pc_o 0x3000, 0x3004, 0x3008, 0x300C; redirect_o 0.
REQ-034 pc=0x3010, stall_i=1 with br_req_i (target 0x3400), hold 2 cycles, then release -> pend_o=1 for 2 cycles, pc 0x3010 held, then pc_o=0x3400, redirect_o pulse, pend_o=0.
REQ-035 In PEND (target 0x3400), exc_req_i=1 with stall_i=1 -> pc_o=0x4180 next cycle, pend_o=0; later advance gives 0x4184, not 0x3400.
REQ-036 exc_req_i, eret_req_i (epc 0x3020) and br_req_i asserted together -> pc_o=0x4180; next cycle eret_req_i alone -> pc_o=0x3020.
REQ-037 pc forced to 0xFFFF_FFFC via eret, advance -> pc_o=0x0000_0000; with PC_ALIGN_CHECK_EN, adel_o=1 and exccode_o=4 for both cycles.
REQ-038 eret to 0x3002 with PC_ALIGN_CHECK_EN -> adel_o=1; without the macro -> adel_o=0.
